// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: steps one shared MAC through all FIR taps for each accepted sample
module fir_mac_sequencer #(
   parameter int NTAPS = 24,
   parameter int DW    = 8,
   parameter int AW    = 5,
   parameter int PIPE  = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [DW-1:0] mem_wdata,
   output logic [AW-1:0] mem_raddr,
   output logic [AW-1:0] coef_addr,
   output logic          mac_en,
   output logic          mac_clr,
   output logic          mac_last,
   output logic          out_valid,
   output logic          busy
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
   localparam int DCW = PIPE > 1 ? $clog2(PIPE) : 1;
   localparam logic [AW-1:0] KLAST = AW'(NTAPS - 1);
   localparam logic [DCW-1:0] DLAST = DCW'(PIPE > 0 ? PIPE - 1 : 0);
   state_t state;
   logic [AW-1:0] wr_ptr;
   logic [DCW-1:0] dcnt;
   // every output is registered from the state being entered; coef_addr doubles as the tap index k
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         dcnt      <= '0;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_waddr <= '0;
         mem_wdata <= '0;
         mem_raddr <= '0;
         coef_addr <= '0;
         mac_en    <= 1'b0;
         mac_clr   <= 1'b0;
         mac_last  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         mem_we    <= 1'b0;
         mac_en    <= 1'b0;
         mac_clr   <= 1'b0;
         mac_last  <= 1'b0;
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  state     <= LOAD;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_waddr <= wr_ptr;
                  mem_wdata <= in_data;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            LOAD: begin
               state     <= RUN;
               mac_en    <= 1'b1;
               mac_clr   <= 1'b1;
               mac_last  <= NTAPS == 1;
               coef_addr <= '0;
               mem_raddr <= wr_ptr;
            end
            RUN: begin
               if (coef_addr == KLAST) begin
                  state     <= PIPE > 0 ? DRAIN : DONE;
                  out_valid <= PIPE == 0;
                  dcnt      <= '0;
               end else begin
                  mac_en    <= 1'b1;
                  mac_last  <= coef_addr + 1'b1 == KLAST;
                  coef_addr <= coef_addr + 1'b1;
                  mem_raddr <= mem_raddr == '0 ? KLAST : mem_raddr - 1'b1;
               end
            end
            DRAIN: begin
               if (dcnt == DLAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               busy     <= 1'b0;
               in_ready <= 1'b1;
               wr_ptr   <= wr_ptr == KLAST ? '0 : wr_ptr + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed cycle-by-cycle checks of the FIR MAC sequencer schedule
module tb_fir_mac_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [7:0] in_data = '0;
   logic mem_we, mac_en, mac_clr, mac_last, out_valid, busy;
   logic [4:0] mem_waddr, mem_raddr, coef_addr;
   logic [7:0] mem_wdata;
   int total = 0;
   int bad = 0;
   fir_mac_sequencer #(.NTAPS(24), .DW(8), .AW(5), .PIPE(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_raddr(mem_raddr),
      .coef_addr(coef_addr), .mac_en(mac_en), .mac_clr(mac_clr), .mac_last(mac_last),
      .out_valid(out_valid), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic all_zero(input string tag);
      chk(tag, int'({in_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, coef_addr,
                     mac_en, mac_clr, mac_last, out_valid, busy}), 0);
   endtask
   // offers one sample, then checks every output on each cycle up to the return to IDLE;
   // stop_i > 0 asserts rst at that cycle offset instead of finishing
   task automatic send(input logic [7:0] d, input int ptr, input bit hold, input int stop_i);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", int'(in_ready), 1);
      in_valid = 1'b1;
      in_data = d;
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
      for (int i = 1; i <= 29; i++) begin
         int k;
         k = i - 2;
         @(negedge clk);
         chk("mem_we", int'(mem_we), int'(i == 1));
         if (i == 1) begin
            chk("waddr", int'(mem_waddr), ptr);
            chk("wdata", int'(mem_wdata), int'(d));
         end
         chk("mac_en", int'(mac_en), int'(i >= 2 && i <= 25));
         if (i >= 2 && i <= 25) begin
            chk("coef", int'(coef_addr), k);
            chk("raddr", int'(mem_raddr), (ptr - k + 24) % 24);
         end
         chk("mac_clr", int'(mac_clr), int'(i == 2));
         chk("mac_last", int'(mac_last), int'(i == 25));
         chk("out_valid", int'(out_valid), int'(i == 28));
         chk("busy", int'(busy), int'(i <= 28));
         chk("in_ready", int'(in_ready), int'(i == 29));
         if (i == stop_i) begin
            rst = 1'b1;
            return;
         end
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      all_zero("reset_outputs");
      rst = 1'b0;
      @(negedge clk);
      chk("rel_ready", int'(in_ready), 1);
      chk("rel_busy", int'(busy), 0);
      send(8'd5, 0, 1'b0, 0);
      for (int v = 1; v <= 24; v++) send(8'(v), v % 24, v < 24, 0);
      send(8'd7, 1, 1'b0, 11);
      @(negedge clk);
      all_zero("run_reset");
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_rst_ov", int'(out_valid), 0);
         chk("post_rst_en", int'(mac_en), 0);
      end
      send(8'd9, 0, 1'b0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
